// File: rtl/display_update_sequencer.sv
// AXI4-Lite write master that copies one measurement result (up to four 32-bit words)
// into the Display register bank, then holds off the next update for a refresh gap.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for s_valid; gap counter runs down, s_ready when gap==0
// ST_ADDR_DATA | AW and W channels presented; each valid drops on its own handshake
// ST_RESP    | both channels accepted, BREADY high until BVALID
module display_update_sequencer #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h43C00000,
  parameter int unsigned                   C_NUM_REGS         = 4,
  parameter int unsigned                   C_MIN_INTERVAL     = 1000000
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [4*C_M_AXI_DATA_WIDTH-1:0]   s_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic                              busy,
  output logic [7:0]                        err_cnt,
  output logic [15:0]                       upd_cnt
);

  localparam int unsigned LP_GAP_W = (C_MIN_INTERVAL < 2) ? 1 : $clog2(C_MIN_INTERVAL + 1);
  localparam logic [LP_GAP_W-1:0] LP_GAP_LOAD = LP_GAP_W'(C_MIN_INTERVAL);
  localparam logic [1:0] LP_LAST_IDX = 2'(C_NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_DATA = 2'd1,
    ST_RESP      = 2'd2
  } state_t;

  state_t                          r_state;
  logic [1:0]                      r_idx;
  logic [LP_GAP_W-1:0]             r_gap;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_words [4];
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic                            r_busy;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [7:0]                      r_err_cnt;
  logic [15:0]                     r_upd_cnt;

  logic [1:0]                      w_next_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_next_addr;
  logic                            w_aw_done;
  logic                            w_w_done;
  logic                            w_bresp_err;

  assign w_next_idx  = r_idx + 2'd1;
  assign w_next_addr = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({w_next_idx, 2'b00});
  // A channel counts as done once its valid has dropped or is handshaking now.
  assign w_aw_done   = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done    = !r_wvalid || M_AXI_WREADY;
  assign w_bresp_err = (M_AXI_BRESP != 2'b00);

  assign s_ready       = (r_state == ST_IDLE) && (r_gap == '0);
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign busy          = r_busy;
  assign err_cnt       = r_err_cnt;
  assign upd_cnt       = r_upd_cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_gap     <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_busy    <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_err_cnt <= 8'd0;
      r_upd_cnt <= 16'd0;
      for (int i = 0; i < 4; i++) r_words[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - LP_GAP_W'(1);
          end else if (s_valid) begin
            for (int i = 0; i < 4; i++)
              r_words[i] <= s_data[i*C_M_AXI_DATA_WIDTH +: C_M_AXI_DATA_WIDTH];
            r_idx     <= 2'd0;
            r_awaddr  <= C_BASE_ADDR;
            r_wdata   <= s_data[C_M_AXI_DATA_WIDTH-1:0];
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_ADDR_DATA;
          end
        end

        ST_ADDR_DATA: begin
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
            if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          end
        end

        ST_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready <= 1'b0;
            if (w_bresp_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            // Error responses do not stop the update; the display gets every word.
            if (r_idx != LP_LAST_IDX) begin
              r_idx     <= w_next_idx;
              r_awaddr  <= w_next_addr;
              r_wdata   <= r_words[w_next_idx];
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_ADDR_DATA;
            end else begin
              r_upd_cnt <= r_upd_cnt + 16'd1;
              r_gap     <= LP_GAP_LOAD;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_update_sequencer.sv
// Bench for display_update_sequencer: reactive AXI4-Lite slave, randomized and directed
// stimulus, and a transaction-level model checked against the DUT every cycle.
module tb_display_update_sequencer;

  localparam int          MIN_GAP = 10;
  localparam int          NREG    = 4;
  localparam logic [31:0] BASE    = 32'h43C00000;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic [31:0]  AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY = 1'b0;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY = 1'b0;
  logic [1:0]   BRESP = 2'b00;
  logic         BVALID = 1'b0;
  logic         BREADY;
  logic         busy;
  logic [7:0]   err_cnt;
  logic [15:0]  upd_cnt;

  display_update_sequencer #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_BASE_ADDR        (BASE),
    .C_NUM_REGS         (NREG),
    .C_MIN_INTERVAL     (MIN_GAP)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .M_AXI_AWADDR  (AWADDR),
    .M_AXI_AWPROT  (AWPROT),
    .M_AXI_AWVALID (AWVALID),
    .M_AXI_AWREADY (AWREADY),
    .M_AXI_WDATA   (WDATA),
    .M_AXI_WSTRB   (WSTRB),
    .M_AXI_WVALID  (WVALID),
    .M_AXI_WREADY  (WREADY),
    .M_AXI_BRESP   (BRESP),
    .M_AXI_BVALID  (BVALID),
    .M_AXI_BREADY  (BREADY),
    .busy          (busy),
    .err_cnt       (err_cnt),
    .upd_cnt       (upd_cnt)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // slave knobs; a negative *_dly selects random readiness with *_pct
  int aw_dly = 0, w_dly = 0, aw_pct = 100, w_pct = 100;
  int b_dly_min = 0, b_dly_max = 0, err_pct = 0, err_word = -1;
  bit err_all = 1'b0;

  // transaction-level model
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0, m_aw_pend = 1'b0, m_w_pend = 1'b0, m_b_pend = 1'b0;
  bit          m_aw_done = 1'b0, m_w_done = 1'b0;
  int          m_widx = 0, m_upd = 0, m_err = 0, m_rdy_cyc = 0;
  logic [31:0] m_words [4];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          acc_cnt = 0, acc_edge = 0, acc_gap = 0, last_b_edge = 0, rdy_seen = 0;
  int          aw_cyc = 0, w_cyc = 0;
  bit          rdy_armed = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    bit exp_rdy;
    if (chk_en) begin
      exp_rdy = !m_busy && (cyc >= m_rdy_cyc);
      chk("busy",    32'(busy),    32'(m_busy));
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      chk("upd_cnt", 32'(upd_cnt), 32'(m_upd));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("awvalid", 32'(AWVALID), 32'(m_aw_pend));
      chk("wvalid",  32'(WVALID),  32'(m_w_pend));
      chk("bready",  32'(BREADY),  32'(m_b_pend));
      chk("awprot",  32'(AWPROT),  32'd0);
      chk("wstrb",   32'(WSTRB),   32'hF);
      if (m_aw_pend) chk("awaddr", AWADDR, BASE + 32'(4 * m_widx));
      if (m_w_pend)  chk("wdata",  WDATA,  m_words[m_widx]);
      if (rdy_armed && s_ready) begin
        rdy_seen  = cyc;
        rdy_armed = 1'b0;
      end
      if (m_busy && m_widx == 0) begin
        if (AWVALID) aw_cyc++;
        if (WVALID)  w_cyc++;
      end
      if (ARESET) begin
        m_busy = 0; m_aw_pend = 0; m_w_pend = 0; m_b_pend = 0; m_aw_done = 0; m_w_done = 0;
        m_widx = 0; m_upd = 0; m_err = 0; m_rdy_cyc = 0; rdy_armed = 0;
      end else begin
        if (m_aw_pend && AWREADY) begin
          log_addr.push_back(AWADDR);
          m_aw_pend = 0; m_aw_done = 1;
        end
        if (m_w_pend && WREADY) begin
          log_data.push_back(WDATA);
          m_w_pend = 0; m_w_done = 1;
        end
        if (m_b_pend && BVALID) begin
          m_b_pend = 0;
          if (BRESP != 2'b00 && m_err < 255) m_err++;
          if (m_widx < NREG - 1) begin
            m_widx++;
            m_aw_pend = 1; m_w_pend = 1;
          end else begin
            m_busy      = 0;
            m_upd       = (m_upd + 1) % 65536;
            m_rdy_cyc   = cyc + 1 + MIN_GAP;
            last_b_edge = cyc + 1;
            rdy_armed   = 1;
          end
        end else if (m_aw_done && m_w_done) begin
          m_b_pend = 1; m_aw_done = 0; m_w_done = 0;
        end
        if (exp_rdy && s_valid) begin
          for (int i = 0; i < 4; i++) m_words[i] = s_data[32*i +: 32];
          m_widx = 0; m_busy = 1; m_aw_pend = 1; m_w_pend = 1;
          acc_cnt++;
          acc_edge = cyc + 1;
          acc_gap  = acc_edge - last_b_edge;
          aw_cyc = 0; w_cyc = 0;
        end
      end
    end
  end

  // reactive AXI4-Lite slave
  initial begin
    bit aw_hs, w_hs, b_hs, rst_s, got_aw, got_w;
    int b_cnt, aw_wait, w_wait;
    got_aw = 0; got_w = 0; b_cnt = -1; aw_wait = 0; w_wait = 0;
    forever begin
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      rst_s = ARESET;
      if (AWVALID && !AWREADY) aw_wait++;
      if (aw_hs) aw_wait = 0;
      if (WVALID && !WREADY) w_wait++;
      if (w_hs) w_wait = 0;
      @(posedge ACLK);
      #1;
      if (rst_s) begin
        got_aw = 0; got_w = 0; b_cnt = -1; aw_wait = 0; w_wait = 0;
        BVALID = 1'b0; BRESP = 2'b00;
      end else begin
        if (aw_hs) got_aw = 1;
        if (w_hs)  got_w = 1;
        if (b_hs) begin
          BVALID = 1'b0; BRESP = 2'b00; got_aw = 0; got_w = 0;
        end
        if (got_aw && got_w && !BVALID) begin
          if (b_cnt < 0) b_cnt = $urandom_range(b_dly_max, b_dly_min);
          if (b_cnt == 0) begin
            BVALID = 1'b1;
            if (err_all || m_widx == err_word) BRESP = 2'b10;
            else if ($urandom_range(99) < err_pct) BRESP = ($urandom_range(1) == 0) ? 2'b10 : 2'b11;
            else BRESP = 2'b00;
            b_cnt = -1;
          end else begin
            b_cnt--;
          end
        end
      end
      AWREADY = (aw_dly < 0) ? ($urandom_range(99) < aw_pct) : (aw_wait >= aw_dly);
      WREADY  = (w_dly < 0)  ? ($urandom_range(99) < w_pct)  : (w_wait >= w_dly);
    end
  end

  task automatic send(input logic [127:0] d, input int budget);
    int a0, n;
    a0 = acc_cnt; n = 0;
    s_data = d; s_valid = 1'b1;
    while (acc_cnt == a0 && n < budget) begin
      @(posedge ACLK); #1; n++;
    end
    s_valid = 1'b0;
    if (acc_cnt == a0) timeout("send_accept");
  endtask

  task automatic wait_upd(input int target, input int budget);
    int n;
    n = 0;
    while (m_upd != target && n < budget) begin
      @(posedge ACLK); #1; n++;
    end
    if (m_upd != target) timeout("wait_update");
  endtask

  task automatic pulse_reset();
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    int n;
    repeat (2) @(posedge ACLK);
    #1;
    chk_en = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_awaddr",  AWADDR,       32'd0);

    // single update, always-ready slave
    ea = '{32'h43C00000, 32'h43C00004, 32'h43C00008, 32'h43C0000C};
    ed = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};
    log_addr.delete(); log_data.delete();
    send({32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A}, 50);
    wait_upd(1, 200);
    n = 0;
    while (rdy_armed && n < 50) begin @(posedge ACLK); #1; n++; end
    if (rdy_armed) timeout("t1_ready");
    chk("t1_nwrites", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", log_addr[i], ea[i]);
      chk("t1_data", log_data[i], ed[i]);
    end
    chk("t1_upd", 32'(upd_cnt), 32'd1);
    chk("t1_gap", 32'(rdy_seen - last_b_edge), 32'd10);

    // address channel held off three cycles
    aw_dly = 3;
    log_addr.delete(); log_data.delete();
    send({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 50);
    wait_upd(2, 300);
    aw_dly = 0;
    chk("t2_aw_cycles", 32'(aw_cyc), 32'd4);
    chk("t2_w_cycles",  32'(w_cyc),  32'd1);
    chk("t2_data0", log_data[0], 32'h11111111);
    chk("t2_data3", log_data[3], 32'h44444444);
    chk("t2_addr3", log_addr[3], 32'h43C0000C);

    // SLVERR on the second write
    err_word = 1;
    log_addr.delete(); log_data.delete();
    send({32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 50);
    wait_upd(3, 200);
    err_word = -1;
    chk("t3_err", 32'(err_cnt), 32'd1);
    chk("t3_nwrites", 32'(log_addr.size()), 32'd4);
    chk("t3_addr2", log_addr[2], 32'h43C00008);
    chk("t3_data3", log_data[3], 32'hDDDD0004);

    // s_valid held: second update waits out the gap
    log_addr.delete(); log_data.delete();
    s_data = {32'h0F0F0F0F, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
    s_valid = 1'b1;
    wait_upd(5, 400);
    s_valid = 1'b0;
    chk("t4_accept_gap", 32'(acc_gap), 32'd11);
    chk("t4_upd", 32'(upd_cnt), 32'd5);
    chk("t4_nwrites", 32'(log_addr.size()), 32'd8);

    // reset while waiting on BVALID of the second write
    b_dly_min = 30; b_dly_max = 30;
    send({32'h4, 32'h3, 32'h2, 32'h1}, 50);
    n = 0;
    while (!(m_widx == 1 && m_b_pend) && n < 100) begin @(posedge ACLK); #1; n++; end
    if (!(m_widx == 1 && m_b_pend)) timeout("t5_reach_resp");
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    chk("t5_awvalid", 32'(AWVALID), 32'd0);
    chk("t5_wvalid",  32'(WVALID),  32'd0);
    chk("t5_bready",  32'(BREADY),  32'd0);
    chk("t5_busy",    32'(busy),    32'd0);
    chk("t5_upd",     32'(upd_cnt), 32'd0);
    chk("t5_err",     32'(err_cnt), 32'd0);
    b_dly_min = 0; b_dly_max = 0;
    log_addr.delete(); log_data.delete();
    send({32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555}, 50);
    wait_upd(1, 200);
    chk("t5_restart_addr", log_addr[0], 32'h43C00000);
    chk("t5_restart_data", log_data[0], 32'h55555555);

    // randomized traffic
    aw_dly = -1; w_dly = -1; aw_pct = 60; w_pct = 50;
    b_dly_min = 0; b_dly_max = 3; err_pct = 25;
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(2) == 0);
      s_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge ACLK); #1;
    end
    s_valid = 1'b0;
    n = 0;
    while (m_busy && n < 300) begin @(posedge ACLK); #1; n++; end
    if (m_busy) timeout("random_drain");

    // error counter saturation
    aw_dly = 0; w_dly = 0; b_dly_max = 0; err_pct = 0; err_all = 1'b1;
    pulse_reset();
    s_data = {$urandom, $urandom, $urandom, $urandom};
    s_valid = 1'b1;
    wait_upd(65, 3000);
    s_valid = 1'b0;
    err_all = 1'b0;
    chk("t6_err_sat", 32'(err_cnt), 32'd255);
    chk("t6_upd", 32'(upd_cnt), 32'd65);

    repeat (3) @(posedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
